// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - shared state encoding and default width for the waveform sequence driver
package waveform_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COUNT,
        DONE
    } state_t;

endpackage

// File: rtl/waveform_piso.sv
// rtl/waveform_piso.sv - parallel-load, shift-left register with zero fill and registered MSB
module waveform_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_value,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_value;
        end else if (shift_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // After WIDTH shifts the register is all zero, so msb is 0 outside SHIFT
    assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/waveform_seq_driver.sv
// rtl/waveform_seq_driver.sv - accepts a value and drives shift_ena/data, count_ena and a done pulse
module waveform_seq_driver
    import waveform_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_value,
    output logic             shift_ena,
    output logic             data,
    output logic             count_ena,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    MAX_IDX  = CW'(WIDTH);
    localparam logic [CW-1:0]    IDX_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             shift_ena_q, shift_ena_d;
    logic             count_ena_q, count_ena_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;
    logic             shifting;

    assign start_ready = (state_q == IDLE);
    assign load        = start_valid && start_ready;
    assign shifting    = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    idx_d   = '0;
                    cnt_d   = start_value;
                end
            end
            SHIFT: begin
                idx_d = (idx_q == MAX_IDX) ? idx_q : idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    state_d = (cnt_q != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it
        shift_ena_d = (state_d == SHIFT);
        count_ena_d = (state_d == COUNT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            shift_ena_q <= 1'b0;
            count_ena_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shift_ena_q <= shift_ena_d;
            count_ena_q <= count_ena_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    waveform_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift_en  (shifting),
        .load_value(start_value),
        .msb       (data)
    );

    assign shift_ena = shift_ena_q;
    assign count_ena = count_ena_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_waveform_seq_driver.sv
// tb/tb_waveform_seq_driver.sv - self-checking bench for waveform_seq_driver against a cycle-indexed waveform model
module tb_waveform_seq_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic [W-1:0] start_value;
    logic         start_ready;
    logic         shift_ena;
    logic         data;
    logic         count_ena;
    logic         busy;
    logic         done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    waveform_seq_driver #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_value(start_value),
        .shift_ena  (shift_ena),
        .data       (data),
        .count_ena  (count_ena),
        .busy       (busy),
        .done       (done)
    );

    // {start_ready, busy, shift_ena, data, count_ena, done} in cycle k after acceptance of v
    function automatic logic [5:0] model(input int k, input int v);
        bit b;
        if (k >= 1 && k <= W) begin
            b = 1'((v >> (W - k)) & 1);
            return {1'b0, 1'b1, 1'b1, b, 1'b0, 1'b0};
        end
        if (k > W && k <= W + v) return 6'b010010;
        if (k == W + v + 1)      return 6'b010001;
        return 6'b100000;
    endfunction

    function automatic logic [5:0] obs();
        return {start_ready, busy, shift_ena, data, count_ena, done};
    endfunction

    task automatic chk(input string tag, input logic [5:0] o, input logic [5:0] e);
        tests_run++;
        assert (o === e) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b (rdy,busy,sh,data,cnt,done)", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int v, input bit keep_valid, input int next_v, input string tag);
        start_valid = 1'b1;
        start_value = W'(v);
        chk({tag, "_ready"}, obs(), model(0, v));
        tick();
        for (int k = 1; k <= W + v + 1; k++) begin
            chk($sformatf("%s_k%0d", tag, k), obs(), model(k, v));
            start_valid = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
            start_value = keep_valid ? W'(next_v) : W'($urandom);
            tick();
        end
        chk({tag, "_idle"}, obs(), model(0, v));
        start_valid = keep_valid;
        start_value = W'(next_v);
    endtask

    task automatic xfer_abort(input int v, input int k_rst, input string tag);
        start_valid = 1'b1;
        start_value = W'(v);
        chk({tag, "_ready"}, obs(), model(0, v));
        tick();
        for (int k = 1; k <= k_rst; k++) begin
            chk($sformatf("%s_k%0d", tag, k), obs(), model(k, v));
            start_valid = 1'b0;
            start_value = W'($urandom);
            if (k == k_rst) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        for (int j = 0; j < W + v + 3; j++) begin
            chk($sformatf("%s_after%0d", tag, j), obs(), model(0, v));
            tick();
        end
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        start_value = '0;
        tick();
        chk("reset0", obs(), model(0, 0));
        tick();
        chk("reset1", obs(), model(0, 0));
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            start_value = W'($urandom);
            tick();
            chk($sformatf("idle%0d", i), obs(), model(0, 0));
        end

        xfer(13, 1'b0, 0, "v1101");
        xfer(0,  1'b0, 0, "v0");
        xfer(15, 1'b0, 0, "vF");
        xfer(3,  1'b1, 5, "chain3");
        xfer(5,  1'b0, 0, "chain5");
        xfer_abort(9, 2, "rst_shift");
        xfer_abort(6, W + 3, "rst_count");
        xfer(2,  1'b0, 0, "v2");

        for (int i = 0; i < 10; i++) begin
            xfer(int'($urandom_range(0, 15)), 1'b0, 0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
